// File: rtl/packet_source_pkg.sv
// -----------------------------------------------------------------------------
// packet_source_pkg
//   Shared NoC definitions used by traffic sources and their helpers:
//   flit type codes, flit field offsets, the injector FSM encoding, the
//   default LFSR seed and the LFSR next-state function.
// -----------------------------------------------------------------------------
package packet_source_pkg;

    // Flit type, carried in the two MSBs of every flit.
    localparam logic [1:0] FLIT_BODY   = 2'b00;
    localparam logic [1:0] FLIT_HEAD   = 2'b01;
    localparam logic [1:0] FLIT_TAIL   = 2'b10;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    localparam int TYPE_W = 2;

    // Head flit: dest at bit 0, source right above it, sequence number above
    // that. The source and sequence offsets scale with DEST_BITS, so they are
    // given here as multiples of the address width.
    localparam int HEAD_DEST_LSB   = 0;
    localparam int HEAD_SRC_MULT   = 1;   // src LSB = 1 * DEST_BITS
    localparam int HEAD_SEQ_MULT   = 2;   // seq LSB = 2 * DEST_BITS

    // Body / tail flit: sequence number then flit index.
    localparam int BODY_SEQ_LSB = 0;
    localparam int BODY_IDX_LSB = 16;

    localparam int SEQ_W = 16;
    localparam int IDX_W = 8;

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1, shifting
    // toward the MSB with the feedback bit entering at bit 0.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
        logic fb;
        fb = cur[15] ^ cur[13] ^ cur[12] ^ cur[10];
        return {cur[14:0], fb};
    endfunction

endpackage : packet_source_pkg

// File: rtl/packet_source_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
//   16-bit Fibonacci LFSR used as the pseudo-random source of traffic
//   generators. Advances one step per clock while en is high.
//
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   asynchronous, active-low reset (loads the seed)
//     en     in   advance enable
//     q      out  current LFSR value
//
//   A SEED of zero would lock the register at zero forever, so it is
//   replaced by the package default.
// -----------------------------------------------------------------------------
module lfsr16
    import packet_source_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] q
);

    localparam logic [15:0] INIT = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

    logic [15:0] lfsr_q;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples its inputs as they were before the clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= INIT;
        end else if (en) begin
            lfsr_q <= lfsr16_next(lfsr_q);
        end
    end

    assign q = lfsr_q;

endmodule : lfsr16

// File: rtl/packet_source.sv
// -----------------------------------------------------------------------------
// packet_source
//   Synthetic traffic injector for a NoC node's local input port. While send
//   is high it decides, once per idle cycle, whether to start a packet (with
//   probability INJ_RATE/256) and to which pseudo-random destination. A
//   started packet of FLITS_PER_PKT flits is streamed over valid/ready and is
//   always completed, even if send drops meanwhile.
//
//   Parameters:
//     SRC_ID         this node's address (DEST_BITS wide)
//     DEST_BITS      node address width, 1..8
//     DATA_WIDTH     flit width, >= 2*DEST_BITS+18 and >= 26
//     FLITS_PER_PKT  flits per packet, 1..255
//     INJ_RATE       injection probability in 1/256 units, 0..256
//     SEED           LFSR seed (0 is replaced by the default seed)
//
//   Ports:
//     clk        in   rising-edge clock
//     reset      in   asynchronous, active-low reset
//     send       in   injection enable, sampled only while idle
//     out_flit   out  flit to the router local port
//     out_valid  out  flit valid
//     out_ready  in   router accepts the flit
//     busy       out  a packet is in flight
//     pkt_count  out  packets whose tail was accepted, wrapping
// -----------------------------------------------------------------------------
module packet_source
    import packet_source_pkg::*;
#(
    parameter int          SRC_ID        = 0,
    parameter int          DEST_BITS     = 4,
    parameter int          DATA_WIDTH    = 32,
    parameter int          FLITS_PER_PKT = 4,
    parameter int          INJ_RATE      = 64,
    parameter logic [15:0] SEED          = DEFAULT_SEED
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  send,
    output logic [DATA_WIDTH-1:0] out_flit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [15:0]           pkt_count
);

    localparam logic [DEST_BITS-1:0] SRC      = DEST_BITS'(SRC_ID);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(FLITS_PER_PKT - 1);
    // Nine bits so that a rate of 256 compares above every 8-bit draw.
    localparam logic [8:0]           RATE     = 9'(INJ_RATE);
    localparam int                   TYPE_LSB = DATA_WIDTH - TYPE_W;
    localparam int                   SRC_LSB  = HEAD_SRC_MULT * DEST_BITS;
    localparam int                   SEQ_LSB  = HEAD_SEQ_MULT * DEST_BITS;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] flit_q,  flit_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic [SEQ_W-1:0]      seq_q,   seq_d;
    logic [15:0]           cnt_q,   cnt_d;

    logic [15:0]           lfsr_q;
    logic                  lfsr_en;
    logic                  inject;
    logic [DEST_BITS-1:0]  dest_raw;
    logic [DEST_BITS-1:0]  dest_sel;

    // -------------------------------------------------------------------------
    // Random source: advances once per idle cycle with send high, so the
    // decision and the destination both use the value before that step.
    // -------------------------------------------------------------------------
    assign lfsr_en = (state_q == ST_IDLE) && send;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (lfsr_en),
        .q     (lfsr_q)
    );

    assign inject   = ({1'b0, lfsr_q[7:0]} < RATE);
    assign dest_raw = lfsr_q[DEST_BITS+7:8];
    // Never address ourselves: flip the LSB when the draw hits SRC_ID.
    assign dest_sel = (dest_raw == SRC) ? (dest_raw ^ DEST_BITS'(1)) : dest_raw;

    // -------------------------------------------------------------------------
    // Flit builders
    // -------------------------------------------------------------------------
    function automatic logic [DATA_WIDTH-1:0] head_flit(
        input logic [DEST_BITS-1:0] dest,
        input logic [SEQ_W-1:0]     seq
    );
        logic [DATA_WIDTH-1:0] f;
        f = '0;
        f[HEAD_DEST_LSB +: DEST_BITS] = dest;
        f[SRC_LSB       +: DEST_BITS] = SRC;
        f[SEQ_LSB       +: SEQ_W]     = seq;
        f[TYPE_LSB      +: TYPE_W]    = (FLITS_PER_PKT == 1) ? FLIT_SINGLE : FLIT_HEAD;
        return f;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] data_flit(
        input logic [IDX_W-1:0] idx,
        input logic [SEQ_W-1:0] seq
    );
        logic [DATA_WIDTH-1:0] f;
        f = '0;
        f[BODY_SEQ_LSB +: SEQ_W]  = seq;
        f[BODY_IDX_LSB +: IDX_W]  = idx;
        f[TYPE_LSB     +: TYPE_W] = (idx == LAST_IDX) ? FLIT_TAIL : FLIT_BODY;
        return f;
    endfunction

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets its hold value first, so no path through the
    // case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        flit_d  = flit_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (send && inject) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                    flit_d  = head_flit(dest_sel, seq_q);
                end
            end

            ST_SEND: begin
                // out_valid is high throughout SEND, so ready alone is the
                // handshake here.
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        flit_d  = '0;
                        seq_d   = seq_q + 16'd1;
                        cnt_d   = cnt_q + 16'd1;
                    end else begin
                        idx_d  = idx_q + 8'd1;
                        flit_d = data_flit(idx_q + 8'd1, seq_q);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: the flit register is reset along with the control state so that
    // out_flit reads zero after reset instead of a stale partial packet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            flit_q  <= '0;
            idx_q   <= '0;
            seq_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            flit_q  <= flit_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            cnt_q   <= cnt_d;
        end
    end

    // Valid and busy are the SEND state flop itself, so both are registered
    // and both fall immediately when reset is asserted.
    assign out_flit  = flit_q;
    assign out_valid = (state_q == ST_SEND);
    assign busy      = (state_q == ST_SEND);
    assign pkt_count = cnt_q;

endmodule : packet_source
